// File: rtl/sn_request_issuer.sv
// -----------------------------------------------------------------------------
// sn_request_issuer
//
// Queues worklist requests (address + length) from an upstream producer and
// offers them one at a time to a downstream controller, while limiting how
// many requests may be handed off but not yet reported done.
//
// Structure:
//   - A FIFO_DEPTH-entry pending queue (ring buffer).
//   - A separate offer slot that holds the request currently presented on
//     SN_next_*. The slot is always loaded from the queue head on a clock
//     edge, so a freshly enqueued request is never bypassed straight to the
//     slot.
//   - A three-state FSM (EMPTY / OFFER / THROTTLE) around the slot.
//   - An outstanding counter: +1 per consumed offer, -1 per done pulse.
//
// Ports:
//   clk, rst           sole rising-edge clock, synchronous active-high reset
//   enq_valid/ready    upstream handshake; enq_ready is high while not full
//   enq_addr, enq_len  request payload; zero-length requests are swallowed
//   SN_next_op         an offered request is valid on SN_next_addr/len
//   SN_clr_next        controller consumed the offered request (pulse)
//   SN_req_done        controller finished one request (pulse)
//   outstanding        requests handed off and not yet done
//   idle               queue empty, slot empty and nothing outstanding
//   proto_err          sticky: clr without offer, or done with nothing out
// -----------------------------------------------------------------------------
module sn_request_issuer #(
    parameter int ADDR_WIDTH  = 64,
    parameter int WL_LEN_BITS = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int MAX_OUT     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic [ADDR_WIDTH-1:0]        enq_addr,
    input  logic [WL_LEN_BITS-1:0]       enq_len,
    output logic                         SN_next_op,
    output logic [ADDR_WIDTH-1:0]        SN_next_addr,
    output logic [WL_LEN_BITS-1:0]       SN_next_len,
    input  logic                         SN_clr_next,
    input  logic                         SN_req_done,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
    output logic                         idle,
    output logic                         proto_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int OUT_W = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_OFFER    = 2'd1,
        ST_THROTTLE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Pending queue storage and control
    logic [ADDR_WIDTH-1:0]  fifo_addr [FIFO_DEPTH];
    logic [WL_LEN_BITS-1:0] fifo_len  [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       fifo_cnt;

    // Offer slot (data only; its validity is carried by the FSM state)
    logic [ADDR_WIDTH-1:0]  slot_addr;
    logic [WL_LEN_BITS-1:0] slot_len;

    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             clr_acc;
    logic             done_acc;
    logic             under_limit;
    logic             proto_viol;
    logic [OUT_W-1:0] out_nxt;

    assign fifo_empty = (fifo_cnt == '0);
    assign enq_ready  = (fifo_cnt < CNT_W'(FIFO_DEPTH));

    // Zero-length requests complete the handshake but are never stored.
    assign push = enq_valid && enq_ready && (enq_len != '0);

    // A clr only counts while a request is actually being offered; a done
    // only counts if something is (or is just becoming) outstanding, so the
    // counter can never wrap below zero.
    assign clr_acc    = SN_clr_next && (state == ST_OFFER);
    assign done_acc   = SN_req_done && ((outstanding != '0) || clr_acc);
    assign proto_viol = (SN_clr_next && !clr_acc) || (SN_req_done && !done_acc);

    always_comb begin
        out_nxt = outstanding;
        if (clr_acc && !done_acc) begin
            out_nxt = outstanding + OUT_W'(1);
        end else if (!clr_acc && done_acc) begin
            out_nxt = outstanding - OUT_W'(1);
        end
    end

    // Throttle decisions look at the post-edge outstanding count, so a done
    // pulse releases a throttled request on the very next cycle.
    assign under_limit = (out_nxt < OUT_W'(MAX_OUT));

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = under_limit ? ST_OFFER : ST_THROTTLE;
                end
            end
            ST_OFFER: begin
                if (clr_acc) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = under_limit ? ST_OFFER : ST_THROTTLE;
                    end else begin
                        state_nxt = ST_EMPTY;
                    end
                end
            end
            ST_THROTTLE: begin
                if (under_limit) begin
                    state_nxt = ST_OFFER;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Control state: FSM, queue pointers, outstanding counter, error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_EMPTY;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            outstanding <= '0;
            proto_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            outstanding <= out_nxt;
            if (proto_viol) begin
                proto_err <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Data path: queue entries and offer slot carry no reset; their validity
    // is tracked entirely by the control state above.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= enq_addr;
            fifo_len[wr_ptr]  <= enq_len;
        end
        if (pop) begin
            slot_addr <= fifo_addr[rd_ptr];
            slot_len  <= fifo_len[rd_ptr];
        end
    end

    // Offered payload is forced to zero whenever nothing is being offered.
    assign SN_next_op   = (state == ST_OFFER);
    assign SN_next_addr = SN_next_op ? slot_addr : '0;
    assign SN_next_len  = SN_next_op ? slot_len  : '0;

    assign idle = (state == ST_EMPTY) && fifo_empty && (outstanding == '0);

endmodule

// File: tb/tb_sn_request_issuer.sv
// -----------------------------------------------------------------------------
// tb_sn_request_issuer
//
// Self-checking bench for sn_request_issuer with default parameters
// (ADDR_WIDTH=64, WL_LEN_BITS=8, FIFO_DEPTH=4, MAX_OUT=2). A queue-based
// reference model tracks the pending list, the offered request and the
// outstanding count; a directed vector table, hand-written corner sequences
// and a randomized phase are all compared against it and against
// hand-derived constants.
// -----------------------------------------------------------------------------
module tb_sn_request_issuer;

    localparam int AW    = 64;
    localparam int LW    = 8;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic          clk;
    logic          rst;
    logic          enq_valid;
    logic          enq_ready;
    logic [AW-1:0] enq_addr;
    logic [LW-1:0] enq_len;
    logic          SN_next_op;
    logic [AW-1:0] SN_next_addr;
    logic [LW-1:0] SN_next_len;
    logic          SN_clr_next;
    logic          SN_req_done;
    logic [1:0]    outstanding;
    logic          idle;
    logic          proto_err;

    sn_request_issuer #(
        .ADDR_WIDTH (AW),
        .WL_LEN_BITS(LW),
        .FIFO_DEPTH (DEPTH),
        .MAX_OUT    (MAXO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enq_valid   (enq_valid),
        .enq_ready   (enq_ready),
        .enq_addr    (enq_addr),
        .enq_len     (enq_len),
        .SN_next_op  (SN_next_op),
        .SN_next_addr(SN_next_addr),
        .SN_next_len (SN_next_len),
        .SN_clr_next (SN_clr_next),
        .SN_req_done (SN_req_done),
        .outstanding (outstanding),
        .idle        (idle),
        .proto_err   (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [AW-1:0] a;
        logic [LW-1:0] l;
    } req_t;

    req_t          mq[$];
    bit            slot_v;
    bit            slot_off;
    logic [AW-1:0] slot_a;
    logic [LW-1:0] slot_l;
    int            m_out;
    bit            m_err;

    function automatic bit m_op();
        return slot_v && slot_off;
    endfunction

    task automatic model_reset();
        mq.delete();
        slot_v   = 0;
        slot_off = 0;
        slot_a   = '0;
        slot_l   = '0;
        m_out    = 0;
        m_err    = 0;
    endtask

    task automatic model_update(input bit ev, input logic [AW-1:0] a, input logic [LW-1:0] l,
                                input bit c, input bit d, input bit r);
        bit   op, clr_ok, done_ok, can_push;
        int   new_out;
        req_t e;
        if (r) begin
            model_reset();
            return;
        end
        op       = m_op();
        clr_ok   = c && op;
        if (c && !op) m_err = 1;
        done_ok  = d && (m_out > 0 || clr_ok);
        if (d && !done_ok) m_err = 1;
        new_out  = m_out + int'(clr_ok) - int'(done_ok);
        can_push = ev && (mq.size() < DEPTH) && (l != 0);
        if (!slot_v || clr_ok) begin
            if (mq.size() > 0) begin
                e        = mq.pop_front();
                slot_a   = e.a;
                slot_l   = e.l;
                slot_v   = 1;
                slot_off = (new_out < MAXO);
            end else begin
                slot_v   = 0;
                slot_off = 0;
            end
        end else if (!slot_off) begin
            slot_off = (new_out < MAXO);
        end
        if (can_push) mq.push_back('{a: a, l: l});
        m_out = new_out;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        bit op;
        op = m_op();
        chk("m_op",     64'(SN_next_op),   64'(op));
        chk("m_addr",   SN_next_addr,      op ? slot_a : 64'd0);
        chk("m_len",    64'(SN_next_len),  op ? 64'(slot_l) : 64'd0);
        chk("m_out",    64'(outstanding),  64'(m_out));
        chk("m_ready",  64'(enq_ready),    64'(mq.size() < DEPTH));
        chk("m_idle",   64'(idle),         64'(!slot_v && mq.size() == 0 && m_out == 0));
        chk("m_err",    64'(proto_err),    64'(m_err));
    endtask

    // One clock cycle: check current outputs, drive inputs, advance model.
    task automatic step(input bit ev, input logic [AW-1:0] a, input logic [LW-1:0] l,
                        input bit c, input bit d, input bit r);
        compare_model();
        enq_valid   = ev;
        enq_addr    = a;
        enq_len     = l;
        SN_clr_next = c;
        SN_req_done = d;
        rst         = r;
        @(posedge clk);
        model_update(ev, a, l, c, d, r);
        @(negedge clk);
        enq_valid   = 0;
        enq_addr    = '0;
        enq_len     = '0;
        SN_clr_next = 0;
        SN_req_done = 0;
        rst         = 0;
    endtask

    task automatic idle_step();
        step(0, '0, '0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, '0, '0, 0, 0, 1);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_op"},    64'(SN_next_op),  64'd0);
        chk({tag, "_addr"},  SN_next_addr,     64'd0);
        chk({tag, "_len"},   64'(SN_next_len), 64'd0);
        chk({tag, "_out"},   64'(outstanding), 64'd0);
        chk({tag, "_ready"}, 64'(enq_ready),   64'd1);
        chk({tag, "_idle"},  64'(idle),        64'd1);
        chk({tag, "_err"},   64'(proto_err),   64'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit            ev;
        logic [AW-1:0] a;
        logic [LW-1:0] l;
        bit            c;
        bit            d;
        bit            e_op;
        logic [AW-1:0] e_addr;
        logic [LW-1:0] e_len;
        int            e_out;
        bit            e_rdy;
        bit            e_idle;
        bit            e_err;
    } vec_t;

    vec_t tbl[16];

    initial begin
        // watchdog
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [AW-1:0] exp_order[5];
        int            k;
        bit            c, d, r, ev;
        logic [LW-1:0] l;

        enq_valid   = 0;
        enq_addr    = '0;
        enq_len     = '0;
        SN_clr_next = 0;
        SN_req_done = 0;
        rst         = 1;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 0;
        chk_reset_values("por");

        //          ev a          l  c d  op addr       len out rdy idl err
        tbl[0]  = '{1, 64'h1000,  5, 0, 0, 0, 64'h0,    0,  0,  1,  1,  0};
        tbl[1]  = '{0, 64'h0,     0, 0, 0, 0, 64'h0,    0,  0,  1,  0,  0};
        tbl[2]  = '{0, 64'h0,     0, 0, 0, 1, 64'h1000, 5,  0,  1,  0,  0};
        tbl[3]  = '{0, 64'h0,     0, 1, 0, 1, 64'h1000, 5,  0,  1,  0,  0};
        tbl[4]  = '{0, 64'h0,     0, 0, 0, 0, 64'h0,    0,  1,  1,  0,  0};
        tbl[5]  = '{0, 64'h0,     0, 0, 1, 0, 64'h0,    0,  1,  1,  0,  0};
        tbl[6]  = '{0, 64'h0,     0, 0, 0, 0, 64'h0,    0,  0,  1,  1,  0};
        tbl[7]  = '{1, 64'h2000,  3, 0, 0, 0, 64'h0,    0,  0,  1,  1,  0};
        tbl[8]  = '{0, 64'h0,     0, 0, 0, 0, 64'h0,    0,  0,  1,  0,  0};
        tbl[9]  = '{0, 64'h0,     0, 1, 0, 1, 64'h2000, 3,  0,  1,  0,  0};
        tbl[10] = '{1, 64'h3000,  7, 0, 0, 0, 64'h0,    0,  1,  1,  0,  0};
        tbl[11] = '{0, 64'h0,     0, 0, 0, 0, 64'h0,    0,  1,  1,  0,  0};
        tbl[12] = '{0, 64'h0,     0, 1, 1, 1, 64'h3000, 7,  1,  1,  0,  0};
        tbl[13] = '{0, 64'h0,     0, 0, 0, 0, 64'h0,    0,  1,  1,  0,  0};
        tbl[14] = '{0, 64'h0,     0, 0, 1, 0, 64'h0,    0,  1,  1,  0,  0};
        tbl[15] = '{0, 64'h0,     0, 0, 0, 0, 64'h0,    0,  0,  1,  1,  0};

        for (int i = 0; i < 16; i++) begin
            chk($sformatf("tbl%0d_op", i),   64'(SN_next_op),  64'(tbl[i].e_op));
            chk($sformatf("tbl%0d_addr", i), SN_next_addr,     tbl[i].e_addr);
            chk($sformatf("tbl%0d_len", i),  64'(SN_next_len), 64'(tbl[i].e_len));
            chk($sformatf("tbl%0d_out", i),  64'(outstanding), 64'(tbl[i].e_out));
            chk($sformatf("tbl%0d_rdy", i),  64'(enq_ready),   64'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_idle", i), 64'(idle),        64'(tbl[i].e_idle));
            chk($sformatf("tbl%0d_err", i),  64'(proto_err),   64'(tbl[i].e_err));
            step(tbl[i].ev, tbl[i].a, tbl[i].l, tbl[i].c, tbl[i].d, 0);
        end

        // ---- throttle at MAX_OUT, release one cycle after done ----
        do_reset();
        step(1, 64'hA0, 1, 0, 0, 0);
        step(1, 64'hB0, 2, 0, 0, 0);
        step(1, 64'hC0, 3, 1, 0, 0);   // consumes A
        step(0, '0, '0, 1, 0, 0);      // consumes B, C goes to throttle
        for (int i = 0; i < 3; i++) begin
            chk("thr_op_held", 64'(SN_next_op), 64'd0);
            chk("thr_out",     64'(outstanding), 64'd2);
            idle_step();
        end
        step(0, '0, '0, 0, 1, 0);
        chk("thr_release_op",   64'(SN_next_op),  64'd1);
        chk("thr_release_addr", SN_next_addr,     64'hC0);
        chk("thr_release_len",  64'(SN_next_len), 64'd3);
        chk("thr_release_out",  64'(outstanding), 64'd1);
        step(0, '0, '0, 1, 0, 0);
        step(0, '0, '0, 0, 1, 0);
        step(0, '0, '0, 0, 1, 0);
        chk("thr_drained_idle", 64'(idle), 64'd1);

        // ---- fill to full, refuse extra, drain in order across wrap ----
        do_reset();
        for (int i = 0; i < 5; i++) begin
            exp_order[i] = 64'h5000 + 64'(i * 16);
            step(1, exp_order[i], LW'(i + 1), 0, 0, 0);
        end
        chk("full_ready_low", 64'(enq_ready), 64'd0);
        step(1, 64'hDEAD, 9, 0, 0, 0);   // refused while full
        chk("full_still_low", 64'(enq_ready), 64'd0);
        k = 0;
        for (int cyc = 0; cyc < 40 && k < 5; cyc++) begin
            if (m_op()) begin
                chk($sformatf("drain_order%0d", k), SN_next_addr, exp_order[k]);
                k++;
                step(0, '0, '0, 1, (m_out > 0), 0);
            end else begin
                step(0, '0, '0, 0, (m_out > 0), 0);
            end
        end
        chk("drain_count", 64'(k), 64'd5);
        repeat (4) step(0, '0, '0, 0, (m_out > 0), 0);

        // ---- protocol errors are sticky and never move outstanding ----
        do_reset();
        step(0, '0, '0, 0, 1, 0);
        chk("perr_done_flag", 64'(proto_err),   64'd1);
        chk("perr_done_out",  64'(outstanding), 64'd0);
        step(0, '0, '0, 1, 0, 0);
        chk("perr_clr_flag",  64'(proto_err),   64'd1);
        chk("perr_clr_out",   64'(outstanding), 64'd0);
        repeat (3) idle_step();
        chk("perr_sticky",    64'(proto_err),   64'd1);

        // ---- reset mid-operation drops everything ----
        do_reset();
        step(1, 64'h7000, 1, 0, 0, 0);
        step(1, 64'h7010, 1, 0, 0, 0);
        step(1, 64'h7020, 1, 1, 0, 0);
        step(1, 64'h7030, 1, 1, 0, 0);
        step(1, 64'h7040, 1, 0, 0, 0);
        chk("mid_out_before", 64'(outstanding), 64'd2);
        do_reset();
        chk_reset_values("midrst");
        step(1, 64'h9999, 0, 0, 0, 0);   // zero-length: accepted, dropped
        for (int i = 0; i < 6; i++) begin
            chk("len0_never_offered", 64'(SN_next_op), 64'd0);
            chk("len0_idle",          64'(idle),       64'd1);
            idle_step();
        end

        // ---- randomized phase against the model ----
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            ev = ($urandom_range(0, 1) == 1);
            l  = ($urandom_range(0, 3) == 0) ? '0 : LW'($urandom);
            c  = m_op() ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 63) == 0);
            d  = (m_out > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 63) == 0);
            r  = ($urandom_range(0, 255) == 0);
            step(ev, {$urandom, $urandom}, l, c, d, r);
        end
        compare_model();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
